mem_array_initiator: RTL and testbench

Request-side controller for the 40-bank memory array (4 tops × 10 banks, 12-bit word address, 32-bit data). It accepts single read/write requests on a valid/ready port and decodes a flat 18-bit address into a one-hot 40-bit bank select plus word address. It drives one access cycle to the array, captures read data after a fixed latency, and returns one response per request on a valid/ready port. It sits between the system bus adapter and the memory array top.

---
 rtl/mem_init_pkg.sv | 17 +
 rtl/mem_csel_decode.sv | 21 ++
 rtl/mem_array_initiator.sv | 133 +++++++++++++
 tb/tb_mem_array_initiator.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_init_pkg.sv
// Shared constants and FSM state type for the memory-array initiator.
// Default build: rsp_err tied 0; define MEM_INIT_RANGE_CHECK_EN to flag bad banks.
package mem_init_pkg;
  localparam int NUM_BANKS     = 40;
  localparam int BANKS_PER_TOP = 10;
  localparam int BANK_W        = 6;
  localparam int WADDR_W       = 12;
  localparam int DATA_W        = 32;
  localparam int ADDR_W        = BANK_W + WADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RWAIT,
    RSP
  } state_t;
endpackage

// File: rtl/mem_csel_decode.sv
// Combinational bank index to one-hot chip select with range flag.
// Indices at or above N select nothing and clear in_range.
module mem_csel_decode
  import mem_init_pkg::*;
#(
  parameter int N = 40
) (
  input  logic [BANK_W-1:0] idx,
  output logic [N-1:0]      csel,
  output logic              in_range
);

  always_comb begin
    csel     = '0;
    in_range = (int'(idx) < N);
    for (int i = 0; i < N; i++) begin
      if (idx == BANK_W'(i)) csel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_array_initiator.sv
// Single-outstanding request controller for the banked memory array.
// MEM_INIT_RANGE_CHECK_EN: report out-of-range bank indices on rsp_err.
module mem_array_initiator
  import mem_init_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int NUM_BANKS = mem_init_pkg::NUM_BANKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_we,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [NUM_BANKS-1:0] mem_csel,
  output logic                 mem_we,
  output logic [WADDR_W-1:0]   mem_w_addr,
  output logic [WADDR_W-1:0]   mem_r_addr,
  output logic [DATA_W-1:0]    mem_w_data,
  input  logic [DATA_W-1:0]    mem_r_data
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 we_q;
  logic                 in_range_q;
  logic                 err_q;
  logic [NUM_BANKS-1:0] dec_csel;
  logic                 dec_in_range;

  mem_csel_decode #(
    .N(NUM_BANKS)
  ) u_dec (
    .idx     (req_addr[ADDR_W-1:WADDR_W]),
    .csel    (dec_csel),
    .in_range(dec_in_range)
  );

  assign rsp_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      in_range_q <= 1'b0;
      err_q      <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_we     <= 1'b0;
      rsp_rdata  <= '0;
      mem_csel   <= '0;
      mem_we     <= 1'b0;
      mem_w_addr <= '0;
      mem_r_addr <= '0;
      mem_w_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            we_q       <= req_we;
            in_range_q <= dec_in_range;
            mem_csel   <= dec_csel;
            mem_we     <= req_we & dec_in_range;
            if (req_we) begin
              mem_w_addr <= req_addr[WADDR_W-1:0];
              mem_w_data <= req_wdata;
            end else begin
              mem_r_addr <= req_addr[WADDR_W-1:0];
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          mem_csel   <= '0;
          mem_we     <= 1'b0;
          mem_w_addr <= '0;
          mem_r_addr <= '0;
          mem_w_data <= '0;
          cnt        <= CNT_W'(RD_LAT - 1);
          if (we_q) begin
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
            rsp_rdata <= '0;
`ifdef MEM_INIT_RANGE_CHECK_EN
            err_q     <= ~in_range_q;
`else
            err_q     <= 1'b0;
`endif
            state     <= RSP;
          end else begin
            state <= RWAIT;
          end
        end
        RWAIT: begin
          if (cnt == '0) begin
            // Unselected banks leave mem_r_data floating; never forward it.
            rsp_rdata <= in_range_q ? mem_r_data : '0;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b0;
`ifdef MEM_INIT_RANGE_CHECK_EN
            err_q     <= ~in_range_q;
`else
            err_q     <= 1'b0;
`endif
            state     <= RSP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_array_initiator.sv
// Self-checking bench: vector table, random traffic vs. a word-level model.
// Expected rsp_err follows MEM_INIT_RANGE_CHECK_EN.
module tb_mem_array_initiator;
  import mem_init_pkg::*;

  localparam int RD_LAT = 3;
`ifdef MEM_INIT_RANGE_CHECK_EN
  localparam bit ERR_OOR = 1'b1;
`else
  localparam bit ERR_OOR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [39:0] mem_csel;
  logic        mem_we;
  logic [11:0] mem_w_addr;
  logic [11:0] mem_r_addr;
  logic [31:0] mem_w_data;
  logic [31:0] mem_r_data;

  int n_pass = 0;
  int n_checks = 0;

  mem_array_initiator #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_csel(mem_csel), .mem_we(mem_we),
    .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
  );

  always #5 clk = ~clk;

  // Array model: data appears RD_LAT cycles after the access cycle.
  logic [31:0] arr [int];
  logic [31:0] pipe [RD_LAT];
  assign mem_r_data = pipe[RD_LAT-1];

  always @(posedge clk) begin : arr_model
    int hit;
    int k;
    logic [31:0] d;
    hit = -1;
    d = 32'hBAD0BAD0;
    for (int i = 0; i < 40; i++) if (mem_csel[i]) hit = i;
    if (hit >= 0 && mem_we) begin
      k = hit * 4096 + int'(mem_w_addr);
      arr[k] = mem_w_data;
    end
    if (hit >= 0 && !mem_we) begin
      k = hit * 4096 + int'(mem_r_addr);
      d = arr.exists(k) ? arr[k] : 32'h0;
    end
    pipe[0] <= d;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  // Reference: flat word store keyed by bank*4096+word.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(input logic [17:0] a);
    int b;
    int k;
    b = int'(a[17:12]);
    k = b * 4096 + int'(a[11:0]);
    if (b >= 40) return 32'h0;
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  function automatic logic ref_err(input logic [17:0] a);
    return ERR_OOR && (int'(a[17:12]) >= 40);
  endfunction

  task automatic ref_apply(input logic we, input logic [17:0] a,
                           input logic [31:0] d);
    int b;
    b = int'(a[17:12]);
    if (we && b < 40) ref_mem[b * 4096 + int'(a[11:0])] = d;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic txn(input logic we, input logic [17:0] a,
                     input logic [31:0] d, input int hold,
                     input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int b;
    logic [39:0] ecsel;
    logic [31:0] snap;
    logic stable;
    logic rdy_bad;
    b = int'(a[17:12]);
    ecsel = (b < 40) ? (40'd1 << b) : 40'd0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("access_csel", 64'(mem_csel), 64'(ecsel));
    chk("access_we", 64'(mem_we), 64'(we && b < 40));
    chk("access_addr", 64'(we ? mem_w_addr : mem_r_addr), 64'(a[11:0]));
    if (we) chk("access_wdata", 64'(mem_w_data), 64'(d));
    n = 1;
    rdy_bad = req_ready;
    while (!rsp_valid && n < RD_LAT + 10) begin
      @(negedge clk);
      n++;
      if (req_ready) rdy_bad = 1'b1;
    end
    chk("rsp_latency", 64'(n), 64'(we ? 2 : 2 + RD_LAT));
    chk("busy_ready_low", 64'(rdy_bad), 64'd0);
    if (!rsp_valid) return;
    chk("csel_cleared", 64'(mem_csel), 64'd0);
    chk("rsp_we", 64'(rsp_we), 64'(we));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    snap = rsp_rdata;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== snap || rsp_we !== we || req_ready)
        stable = 1'b0;
    end
    if (hold > 0) chk("rsp_hold_stable", 64'(stable), 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_released", 64'(rsp_valid), 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    logic seen;
    logic oh_ok;
    logic sp_ok;
    int acc[$];
    logic        rwe;
    logic [17:0] ra;
    logic [31:0] rd;
    logic [31:0] erd;

    vecs[0] = '{1'b1, 18'h00005, 32'hDEADBEEF, 0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 18'h00005, 32'h0, 0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 18'h27FFF, 32'h0, 0, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 18'h27FFF, 32'h12345678, 0, 32'h0, 1'b0};
    vecs[4] = '{1'b0, 18'h27FFF, 32'h0, 5, 32'h12345678, 1'b0};
    vecs[5] = '{1'b1, 18'h28001, 32'hCAFEF00D, 0, 32'h0, ERR_OOR};
    vecs[6] = '{1'b0, 18'h28001, 32'h0, 0, 32'h0, ERR_OOR};
    vecs[7] = '{1'b0, 18'h3FABC, 32'h0, 2, 32'h0, ERR_OOR};
    vecs[8] = '{1'b1, 18'h0A000, 32'hAAAA5555, 0, 32'h0, 1'b0};
    vecs[9] = '{1'b0, 18'h0A000, 32'h0, 0, 32'hAAAA5555, 1'b0};

    #1 rst = 1'b1;
    #1;
    chk("reset_ctl", {19'd0, rsp_valid, rsp_we, rsp_err, mem_we, req_ready,
                      mem_csel}, 64'd0);
    chk("reset_data", {rsp_rdata, mem_w_data}, 64'd0);
    chk("reset_addr", {40'd0, mem_w_addr, mem_r_addr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!req_ready && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      ref_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
          vecs[i].exp_rd, vecs[i].exp_err);
    end

    for (int i = 0; i < 150; i++) begin
      rwe = 1'($urandom_range(0, 1));
      ra = {6'($urandom_range(0, 45)), 12'($urandom_range(0, 15))};
      rd = $urandom;
      erd = rwe ? 32'h0 : ref_read(ra);
      txn(rwe, ra, rd, int'($urandom_range(0, 2)), erd, ref_err(ra));
      ref_apply(rwe, ra, rd);
    end

    // Reset while the read waits on the array.
    ref_apply(1'b1, 18'h03010, 32'h5A5A1234);
    txn(1'b1, 18'h03010, 32'h5A5A1234, 0, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = 18'h03010;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {19'd0, rsp_valid, rsp_we, rsp_err, mem_we, req_ready,
                       mem_csel}, 64'd0);
    chk("midrst_data", {rsp_rdata, mem_w_data}, 64'd0);
    chk("midrst_addr", {40'd0, mem_w_addr, mem_r_addr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    rsp_ready = 1'b0;
    chk("no_rsp_after_reset", 64'(seen), 64'd0);
    txn(1'b0, 18'h03010, 32'h0, 0, 32'h5A5A1234, 1'b0);

    // Back-to-back writes with valid and ready held high.
    ref_apply(1'b1, 18'h07020, 32'h0BADF00D);
    @(negedge clk);
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 18'h07020;
    req_wdata = 32'h0BADF00D;
    rsp_ready = 1'b1;
    oh_ok = 1'b1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (mem_csel != 40'd0) begin
        acc.push_back(c);
        if (mem_csel != (40'd1 << 7) || !mem_we) oh_ok = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_count", 64'(acc.size()), 64'd5);
    sp_ok = 1'b1;
    for (int i = 1; i < acc.size(); i++)
      if (acc[i] - acc[i-1] != 3) sp_ok = 1'b0;
    chk("b2b_spacing", 64'(sp_ok), 64'd1);
    chk("b2b_onehot", 64'(oh_ok), 64'd1);
    n = 0;
    while (!(req_ready && !rsp_valid) && n < 10) begin
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    chk("b2b_drain", 64'(req_ready && !rsp_valid), 64'd1);
    txn(1'b0, 18'h07020, 32'h0, 0, ref_read(18'h07020), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
